// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
// imem_ready/imem_rdata always refer to the address presented in the same cycle.
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;

  modport master (output req, addr, input  ready, rdata);
  modport slave  (input  req, addr, output ready, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives the PC register's next value, fetches from
// instruction memory and fills the IF/ID register. A one-entry skid buffer
// absorbs a word that returns while ID is stalled, so no refetch is needed.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc,
  output logic [31:0]  new_pc,
  fetch_unit_if.master imem,
  input  logic         stall,
  input  logic         redirect,
  input  logic [31:0]  redirect_target,
  output logic         if_valid,
  output logic [31:0]  if_instr,
  output logic [31:0]  if_pc4,
  output logic [31:0]  fetch_count
);

  typedef enum logic {S_FETCH = 1'b0, S_FULL = 1'b1} state_t;

  state_t      state, state_nxt;
  logic [31:0] skid_instr, skid_pc4;
  logic [31:0] pc4;
  logic        accept;
  logic        ld_mem, ld_skid, cap_skid, bubble;

  assign accept    = !stall;
  assign pc4       = pc + 32'd4;
  assign imem.addr = pc;

  // Next state, next PC, request and IF/ID load controls; redirect then reset override.
  always_comb begin
    state_nxt = state;
    new_pc    = pc;
    imem.req  = 1'b0;
    ld_mem    = 1'b0;
    ld_skid   = 1'b0;
    cap_skid  = 1'b0;
    bubble    = 1'b0;
    case (state)
      S_FETCH: begin
        imem.req = 1'b1;
        if (imem.ready) begin
          new_pc = pc4;
          if (accept) ld_mem = 1'b1;
          else begin
            cap_skid  = 1'b1;
            state_nxt = S_FULL;
          end
        end else if (accept) begin
          bubble = 1'b1;
        end
      end
      S_FULL: begin
        if (accept) begin
          ld_skid   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_FETCH;
    endcase
    // Redirect flushes IF/ID, drops any returning word and abandons the skid.
    if (redirect) begin
      new_pc    = redirect_target & ~32'h3;
      state_nxt = S_FETCH;
      ld_mem    = 1'b0;
      ld_skid   = 1'b0;
      cap_skid  = 1'b0;
      bubble    = 1'b1;
    end
    // While reset is held the PC register is steered to RESET_PC with no fetch.
    if (!reset) begin
      new_pc   = RESET_PC;
      imem.req = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // IF/ID register, skid buffer and delivered-instruction counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc4      <= 32'h0;
      skid_instr  <= 32'h0;
      skid_pc4    <= 32'h0;
      fetch_count <= 32'h0;
    end else begin
      if (ld_mem) begin
        if_valid <= 1'b1;
        if_instr <= imem.rdata;
        if_pc4   <= pc4;
      end else if (ld_skid) begin
        if_valid <= 1'b1;
        if_instr <= skid_instr;
        if_pc4   <= skid_pc4;
      end else if (bubble) begin
        if_valid <= 1'b0;
      end
      if (ld_mem || ld_skid) fetch_count <= fetch_count + 32'd1;
      if (cap_skid) begin
        skid_instr <= imem.rdata;
        skid_pc4   <= pc4;
      end else if (redirect) begin
        skid_instr <= 32'h0;
        skid_pc4   <= 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a PC register closes the new_pc loop, a queue-based
// model predicts IF/ID contents, and directed steps pin literal expectations
// before a randomized run.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc_reg = 32'h0;
  logic [31:0] new_pc;
  logic        stall = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        if_valid;
  logic [31:0] if_instr, if_pc4, fetch_count;

  fetch_unit_if imem ();

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .pc(pc_reg), .new_pc(new_pc), .imem(imem.master),
    .stall(stall), .redirect(redirect), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc4(if_pc4), .fetch_count(fetch_count)
  );

  always #10 clk = ~clk;

  // The PC register: loads new_pc on every rising edge, no enable.
  always @(posedge clk) pc_reg <= new_pc;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: the IF/ID register as three variables, the skid as a
  // queue of {instr, pc4} words, plus a delivery counter.
  logic        m_valid = 1'b0;
  logic [31:0] m_instr = 32'h0, m_pc4 = 32'h0, m_count = 32'h0;
  logic [63:0] m_skid[$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_valid = 1'b0; m_instr = 32'h0; m_pc4 = 32'h0; m_count = 32'h0;
      m_skid.delete();
    end else if (redirect) begin
      m_valid = 1'b0;
      m_skid.delete();
    end else if (m_skid.size() != 0) begin
      if (!stall) begin
        {m_instr, m_pc4} = m_skid.pop_front();
        m_valid = 1'b1;
        m_count = m_count + 1;
      end
    end else if (imem.ready) begin
      if (!stall) begin
        m_valid = 1'b1; m_instr = imem.rdata; m_pc4 = pc_reg + 32'd4;
        m_count = m_count + 1;
      end else begin
        m_skid.push_back({imem.rdata, pc_reg + 32'd4});
      end
    end else if (!stall) begin
      m_valid = 1'b0;
    end
  end

  // Compare process: every falling edge, combinational and registered outputs.
  always @(negedge clk) begin
    logic        e_req;
    logic [31:0] e_npc;
    e_req = reset && (m_skid.size() == 0);
    if (!reset)                                   e_npc = 32'h0;
    else if (redirect)                            e_npc = redirect_target & 32'hFFFF_FFFC;
    else if (m_skid.size() == 0 && imem.ready)    e_npc = pc_reg + 32'd4;
    else                                          e_npc = pc_reg;
    chk("m_req",   {31'd0, imem.req}, {31'd0, e_req});
    chk("m_newpc", new_pc, e_npc);
    chk("m_addr",  imem.addr, pc_reg);
    chk("m_valid", {31'd0, if_valid}, {31'd0, m_valid});
    chk("m_count", fetch_count, m_count);
    if (m_valid) begin
      chk("m_instr", if_instr, m_instr);
      chk("m_pc4",   if_pc4, m_pc4);
    end
  end

  // One cycle of stimulus: drive just after the rising edge, return at +4.
  task automatic step(input logic r, input logic rdy, input logic [31:0] rd,
                      input logic st, input logic rdr, input logic [31:0] tg);
    @(posedge clk);
    #1;
    reset = r; imem.ready = rdy; imem.rdata = rd;
    stall = st; redirect = rdr; redirect_target = tg;
    #3;
  endtask

  logic [31:0] c0;

  initial begin
    imem.ready = 1'b1; imem.rdata = 32'h0;

    // Reset held with memory ready.
    repeat (3) step(0, 1, $urandom, 0, 0, 0);
    chk("rst_req",   {31'd0, imem.req}, 32'd0);
    chk("rst_newpc", new_pc, 32'h0);
    chk("rst_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // Back-to-back fetch from 0.
    step(1, 1, 32'h2008_0001, 0, 0, 0);
    chk("f0_addr",  imem.addr, 32'h0);
    chk("f0_newpc", new_pc, 32'h4);
    step(1, 1, 32'h2009_0002, 0, 0, 0);
    chk("f1_instr", if_instr, 32'h2008_0001);
    chk("f1_pc4",   if_pc4, 32'h4);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("f2_instr", if_instr, 32'h2009_0002);
    chk("f2_pc4",   if_pc4, 32'h8);
    chk("f2_count", fetch_count, 32'd2);

    // Wait states at 0x10.
    step(1, 0, 32'h0, 0, 1, 32'h10);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("ws0_newpc", new_pc, 32'h10);
    chk("ws0_valid", {31'd0, if_valid}, 32'd0);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("ws1_newpc", new_pc, 32'h10);
    chk("ws1_valid", {31'd0, if_valid}, 32'd0);
    step(1, 1, 32'h1111_0010, 0, 0, 0);
    chk("ws2_newpc", new_pc, 32'h14);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("ws3_pc4",   if_pc4, 32'h14);
    chk("ws3_valid", {31'd0, if_valid}, 32'd1);

    // Stall while data returns at 0x20.
    step(1, 0, 32'h0, 0, 1, 32'h20);
    step(1, 1, 32'hAAAA_0001, 1, 0, 0);
    chk("st0_newpc", new_pc, 32'h24);
    c0 = fetch_count;
    step(1, 1, 32'hBBBB_0002, 1, 0, 0);
    chk("st1_req",   {31'd0, imem.req}, 32'd0);
    chk("st1_newpc", new_pc, 32'h24);
    chk("st1_count", fetch_count, c0);
    step(1, 1, 32'hBBBB_0002, 1, 0, 0);
    step(1, 1, 32'hBBBB_0002, 0, 0, 0);
    chk("st3_req",   {31'd0, imem.req}, 32'd0);
    step(1, 1, 32'hCCCC_0024, 0, 0, 0);
    chk("st4_instr", if_instr, 32'hAAAA_0001);
    chk("st4_pc4",   if_pc4, 32'h24);
    chk("st4_newpc", new_pc, 32'h28);
    chk("st4_req",   {31'd0, imem.req}, 32'd1);

    // Redirect racing ready+stall, then redirect out of the full state.
    step(1, 0, 32'h0, 0, 0, 0);
    c0 = fetch_count;
    step(1, 1, 32'hDEAD_0001, 1, 1, 32'h103);
    chk("rd0_newpc", new_pc, 32'h100);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("rd1_valid", {31'd0, if_valid}, 32'd0);
    chk("rd1_count", fetch_count, c0);
    chk("rd1_addr",  imem.addr, 32'h100);
    step(1, 1, 32'hDEAD_0002, 1, 0, 0);
    step(1, 0, 32'h0, 0, 1, 32'h200);
    chk("rd2_newpc", new_pc, 32'h200);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("rd3_valid", {31'd0, if_valid}, 32'd0);
    chk("rd3_count", fetch_count, c0);
    chk("rd3_req",   {31'd0, imem.req}, 32'd1);

    // PC wrap at the top of the address space.
    step(1, 0, 32'h0, 0, 1, 32'hFFFF_FFFF);
    step(1, 1, 32'h5555_AAAA, 0, 0, 0);
    chk("wr0_addr",  imem.addr, 32'hFFFF_FFFC);
    chk("wr0_newpc", new_pc, 32'h0);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("wr1_pc4",   if_pc4, 32'h0);
    chk("wr1_valid", {31'd0, if_valid}, 32'd1);

    // Asynchronous reset in the full state, mid-cycle.
    step(1, 1, 32'h7777_0001, 1, 0, 0);
    step(1, 1, 32'h7777_0002, 1, 0, 0);
    chk("ar0_req", {31'd0, imem.req}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ar1_valid", {31'd0, if_valid}, 32'd0);
    chk("ar1_count", fetch_count, 32'd0);
    chk("ar1_newpc", new_pc, 32'h0);
    chk("ar1_req",   {31'd0, imem.req}, 32'd0);
    step(0, 0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    step(1, 0, 32'h0, 0, 0, 0);
    chk("ar2_valid", {31'd0, if_valid}, 32'd0);
    chk("ar2_count", fetch_count, 32'd0);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0), $urandom,
           ($urandom_range(0, 2) == 0), ($urandom_range(0, 15) == 0), $urandom);
    end
    step(1, 0, 32'h0, 0, 0, 0);
    @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit that drives the PC register's next-value input and consumes its current value. Each cycle it presents the current PC to instruction memory, captures the returned word into the IF/ID pipeline register, and computes the next PC. Because the PC register loads on every clock edge with no enable, this block implements hold, advance and redirect entirely through `new_pc`. It sits between the PC register, instruction memory and the ID stage.

## Interface
- `RESET_PC`, default 32'h00000000: value driven on `new_pc` while reset is asserted.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-low; asserted (0) clears all state immediately.
- `pc` input 32: current PC-register output.
- `new_pc` output 32: next PC, combinational, sampled by the PC register on the rising edge.
- `imem_req` output 1: fetch request.
- `imem_addr` output 32: fetch address, equal to `pc`.
- `imem_ready` input 1: `imem_rdata` is valid for `imem_addr` in this cycle.
- `imem_rdata` input 32: fetched instruction.
- `stall` input 1: ID cannot accept; IF/ID must hold.
- `redirect` input 1: taken branch or jump; flush and refetch.
- `redirect_target` input 32: new fetch address; bits [1:0] forced to 0.
- `if_valid` output 1: IF/ID holds a live instruction.
- `if_instr` output 32: IF/ID instruction.
- `if_pc4` output 32: PC+4 of the IF/ID instruction.
- `fetch_count` output 32: count of instructions delivered into IF/ID; wraps modulo 2^32.

## Operation
- Two states: `S_FETCH` and `S_FULL`. A one-entry skid buffer (`skid_instr`, `skid_pc4`) is used only in `S_FULL`.
- Accept condition: `accept = !stall`. IF/ID loads when accept is 1.
- **S_FETCH**
  - `imem_req` = 1.
  - `imem_ready` & accept: load IF/ID with (1, `imem_rdata`, pc+4); `new_pc` = pc+4; stay in `S_FETCH`.
  - `imem_ready` & !accept: capture into skid; `new_pc` = pc+4; go to `S_FULL`. IF/ID holds.
  - !`imem_ready`: `new_pc` = pc. If accept, `if_valid` <= 0 (bubble); otherwise IF/ID holds.
- **S_FULL**
  - `imem_req` = 0; `new_pc` = pc.
  - accept: load IF/ID from skid with `if_valid` <= 1; go to `S_FETCH`.
  - !accept: hold.
- **redirect** (highest priority, any state)
  - `new_pc` = {redirect_target[31:2], 2'b00}.
  - `if_valid` <= 0 and skid discarded.
  - Next state is `S_FETCH`.
  - Any `imem_ready` data in the same cycle is dropped and not counted.
  - `imem_req` still follows the current state in that cycle.
- Memory has no outstanding-request tracking. `imem_ready` always refers to the address presented in the same cycle, and the address may change freely between cycles.
- Arithmetic: pc+4 is 32-bit and wraps (0xFFFFFFFC+4 = 0x00000000). `pc` bits [1:0] are not checked.
- `fetch_count` increments by 1 on each edge where `if_valid` is loaded with 1, whether from memory or from skid.
- **Reset asserted (0)**
  - `if_valid` = 0, `if_instr` = 0, `if_pc4` = 0, `fetch_count` = 0.
  - Skid cleared; state = `S_FETCH`.
  - `imem_req` forced to 0; `new_pc` = `RESET_PC`.
- Reset mid-operation (including in `S_FULL`) aborts everything. After release, fetch restarts at the PC register's value.

## Timing
- Zero-wait memory, no stall: one instruction per cycle. Data returned in cycle N appears on `if_*` from cycle N+1, and `pc` advances at the same edge.
- A wait state holds `pc` for as many cycles as `imem_ready` stays low.
- A stall that coincides with returned data costs no refetch: the skid buffer releases on the first cycle `stall` is 0. Fetch resumes in the following cycle.
- Redirect in cycle N: `pc` = target and `if_valid` = 0 from cycle N+1. The first target instruction can appear in IF/ID from cycle N+2.
- `new_pc`, `imem_req` and `imem_addr` are combinational from `pc`, state and inputs. `if_*`, skid and `fetch_count` are registered.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `imem_ready`=1 → `imem_req`=0, `new_pc`=0, `if_valid`=0, `fetch_count`=0. After release with pc=0 and rdata 0x20080001, 0x20090002 → IF/ID shows (0x20080001, pc4 4) then (0x20090002, pc4 8); `fetch_count`=2.
- **Wait states:** `imem_ready` low for 2 cycles at pc=0x10 → `new_pc` stays 0x10 and `if_valid` is 0 for those 2 cycles. On ready, IF/ID gets pc4=0x14 and `new_pc`=0x14.
- **Stall with data:** `stall`=1 for 3 cycles while ready at pc=0x20 → state goes to `S_FULL`, `imem_req`=0, pc held at 0x24, IF/ID unchanged. Stall drops → IF/ID gets the skid word with pc4 0x24, then fetch resumes at 0x24.
- **Redirect races:** redirect to 0x00000103 in the same cycle as ready and `stall` → `new_pc`=0x100, `if_valid` 0 next cycle, data dropped, `fetch_count` unchanged. Repeat from `S_FULL` → skid discarded.
- **Wrap:** pc=0xFFFFFFFC with ready → `new_pc`=0x00000000 and `if_pc4`=0x00000000. `fetch_count` preset near 0xFFFFFFFF by driving fetches wraps to 0.
- **Async reset:** drop `reset` mid-cycle while in `S_FULL` → outputs clear without waiting for a clock edge; no skid data appears after release.
